bcd_scan_mux: RTL and testbench

//   Time-multiplexed scanner for an N-digit common-cathode 7-segment display.

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/scan_prescaler.sv | 30 +++
 rtl/bcd_scan_mux.sv | 132 +++++++++++++
 tb/tb_bcd_scan_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg_scan_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 and flags the last cycle of every slot.
module scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIV = 1000,
  localparam int unsigned CNT_W = clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed BCD digit scanner with guard slots, leading-zero blanking
// and frame-synchronous (tear-free) display update.
module bcd_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV          = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned LZ_BLANK     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        load,
  output logic [BCD_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_start,
  output logic                        update_pending
);

  localparam int unsigned CNT_W   = clog2(DIV);
  localparam int unsigned IDX_W   = clog2(NUM_DIGITS);
  localparam int unsigned FRAME_W = BCD_W * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic                  last_digit;
  logic                  wrap;
  logic                  guard;

  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [FRAME_W-1:0]    shadow_q,  shadow_d;
  logic [FRAME_W-1:0]    pending_q, pending_d;
  logic                  upd_q,     upd_d;
  logic [NUM_DIGITS-1:0] en_q,      en_d;
  logic [BCD_W-1:0]      bcd_q,     bcd_d;
  logic                  fs_q,      fs_d;

  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;
  logic [BCD_W-1:0]      digit_sel;
  logic                  blank_sel;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = tick && last_digit;
  assign guard      = (cnt < CNT_W'(BLANK_CYCLES));

  // Digit i>0 is blank when it and every higher digit are zero.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (shadow_q[i*BCD_W +: BCD_W] == '0);
      lz[i]    = zero_run && (LZ_BLANK != 0);
    end
  end

  always_comb begin
    digit_sel = '0;
    blank_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_sel = shadow_q[i*BCD_W +: BCD_W];
        blank_sel = lz[i];
      end
    end
  end

  // Next state: scan index, double-buffered frame, registered outputs.
  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    upd_d     = upd_q;
    en_d      = '0;
    bcd_d     = BLANK_CODE;
    fs_d      = wrap;

    if (tick) idx_d = last_digit ? '0 : idx_q + IDX_W'(1);

    if (load) pending_d = digits_in;

    // A load on the wrap cycle goes straight to the shadow frame.
    if (wrap) begin
      upd_d = 1'b0;
      if (load)       shadow_d = digits_in;
      else if (upd_q) shadow_d = pending_q;
    end else if (load) begin
      upd_d = 1'b1;
    end

    if (!guard) begin
      en_d  = NUM_DIGITS'(1) << idx_q;
      bcd_d = blank_sel ? BLANK_CODE : digit_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      upd_q     <= 1'b0;
      en_q      <= '0;
      bcd_q     <= BLANK_CODE;
      fs_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      en_q      <= en_d;
      bcd_q     <= bcd_d;
      fs_q      <= fs_d;
    end
  end

  assign bcd_out        = bcd_q;
  assign digit_en       = en_q;
  assign frame_start    = fs_q;
  assign update_pending = upd_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux: one instance with leading-zero blanking, one without.
module tb_bcd_scan_mux;

  localparam int unsigned ND = 4;
  localparam int unsigned DV = 8;
  localparam int unsigned BK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;

  logic [3:0]  bcd, bcd2;
  logic [3:0]  en, en2;
  logic        fs, fs2, up, up2;

  typedef logic [19:0] obs_t;
  obs_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int          m_cnt, m_idx;
  logic [15:0] m_shadow, m_pending;
  logic        m_up;

  bcd_scan_mux #(
    .NUM_DIGITS (ND), .DIV (DV), .BLANK_CYCLES (BK), .LZ_BLANK (1)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .digits_in (digits_in), .load (load),
    .bcd_out (bcd), .digit_en (en), .frame_start (fs), .update_pending (up)
  );

  bcd_scan_mux #(
    .NUM_DIGITS (ND), .DIV (DV), .BLANK_CYCLES (BK), .LZ_BLANK (0)
  ) u_dut_raw (
    .clk (clk), .rst_n (rst_n), .digits_in (digits_in), .load (load),
    .bcd_out (bcd2), .digit_en (en2), .frame_start (fs2), .update_pending (up2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] disp(input logic [15:0] s, input int i, input bit lzb);
    logic [15:0] hi;
    hi = s >> (4 * i);
    if (lzb && i > 0 && hi == 16'h0) return 4'hF;
    return hi[3:0];
  endfunction

  function automatic obs_t observe();
    return {en, bcd, en2, bcd2, fs, up, fs2, up2};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_shadow = 16'h0; m_pending = 16'h0; m_up = 1'b0;
    exp_q.delete();
  endtask

  // Predict the outputs of the next edge, advance the model, then compare.
  task automatic tick_cycle();
    logic       guard, wrap;
    logic [3:0] en_e, b1, b2;
    guard = (m_cnt < int'(BK));
    en_e  = guard ? 4'h0 : 4'(1 << m_idx);
    b1    = guard ? 4'hF : disp(m_shadow, m_idx, 1'b1);
    b2    = guard ? 4'hF : disp(m_shadow, m_idx, 1'b0);
    wrap  = (m_cnt == int'(DV) - 1) && (m_idx == int'(ND) - 1);
    if (wrap) begin
      if (load)      m_shadow = digits_in;
      else if (m_up) m_shadow = m_pending;
      m_up = 1'b0;
    end else if (load) begin
      m_up = 1'b1;
    end
    if (load) m_pending = digits_in;
    if (m_cnt == int'(DV) - 1) begin
      m_cnt = 0;
      m_idx = (m_idx == int'(ND) - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
    exp_q.push_back({en_e, b1, en_e, b2, wrap, m_up, wrap, m_up});
    @(posedge clk);
    #1;
    check_eq("scan", 32'(observe()), 32'(exp_q.pop_front()));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    digits_in = v;
    load      = 1'b1;
    tick_cycle();
    load      = 1'b0;
  endtask

  task automatic run_until_state(input int c, input int i);
    for (int k = 0; k < 64 && !(m_cnt == c && m_idx == i); k++) tick_cycle();
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      tick_cycle();
      seen = fs;
    end
    if (!seen) check_eq("fs_timeout", 32'(0), 32'(1));
  endtask

  // Observe one full frame; record what each digit showed and for how long.
  task automatic check_frame(input string tag, input logic [15:0] exp_lz, input logic [15:0] exp_raw);
    logic [3:0] s1 [ND];
    logic [3:0] s2 [ND];
    int         hits [ND];
    for (int i = 0; i < int'(ND); i++) begin
      s1[i] = 4'hE; s2[i] = 4'hE; hits[i] = 0;
    end
    repeat (ND * DV) begin
      tick_cycle();
      for (int i = 0; i < int'(ND); i++) begin
        if (en == 4'(1 << i)) begin
          s1[i] = bcd; s2[i] = bcd2; hits[i]++;
        end
      end
    end
    check_eq({tag, "_lz"},  32'({s1[3], s1[2], s1[1], s1[0]}), 32'(exp_lz));
    check_eq({tag, "_raw"}, 32'({s2[3], s2[2], s2[1], s2[0]}), 32'(exp_raw));
    for (int i = 0; i < int'(ND); i++) check_eq({tag, "_slot"}, 32'(hits[i]), 32'(DV - BK));
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_en",  32'(en),  32'(0));
    check_eq("rst_bcd", 32'(bcd), 32'(4'hF));
    check_eq("rst_up",  32'(up),  32'(0));
    check_eq("rst_fs",  32'(fs),  32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_cycle();
    tick_cycle();
    check_eq("guard_en", 32'(en), 32'(0));
    tick_cycle();
    check_eq("first_en", 32'(en), 32'(4'b0001));

    pulse_load(16'h1234);
    wait_fs();
    check_frame("scan1234", 16'h1234, 16'h1234);

    pulse_load(16'h0007);
    wait_fs();
    check_frame("lz0007", 16'hFFF7, 16'h0007);
    pulse_load(16'h0000);
    wait_fs();
    check_frame("lz0000", 16'hFFF0, 16'h0000);
    pulse_load(16'h0100);
    wait_fs();
    check_frame("lz0100", 16'hF100, 16'h0100);

    run_until_state(3, 1);
    pulse_load(16'h5678);
    check_eq("sync_pending", 32'(up), 32'(1));
    wait_fs();
    check_eq("sync_cleared", 32'(up), 32'(0));
    check_frame("sync5678", 16'h5678, 16'h5678);

    run_until_state(1, 0);
    pulse_load(16'h1111);
    tick_cycle();
    tick_cycle();
    pulse_load(16'h2222);
    wait_fs();
    check_frame("last2222", 16'h2222, 16'h2222);

    run_until_state(int'(DV) - 1, int'(ND) - 1);
    pulse_load(16'h9999);
    check_eq("wrap_up", 32'(up), 32'(0));
    check_eq("wrap_fs", 32'(fs), 32'(1));
    check_frame("wrap9999", 16'h9999, 16'h9999);

    pulse_load(16'h00A0);
    wait_fs();
    check_frame("pass00A0", 16'hFFA0, 16'h00A0);

    pulse_load(16'h4321);
    run_until_state(4, 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_en",  32'(en),  32'(0));
    check_eq("midrst_bcd", 32'(bcd), 32'(4'hF));
    check_eq("midrst_up",  32'(up),  32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_cycle();
    check_eq("midrst_guard0", 32'(en), 32'(0));
    tick_cycle();
    check_eq("midrst_guard1", 32'(en), 32'(0));
    tick_cycle();
    check_eq("midrst_en0",  32'(en),  32'(4'b0001));
    check_eq("midrst_bcd0", 32'(bcd), 32'(4'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
